// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, defaults and FSM encoding for the fetch unit
package fetch_pkg;
  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0;
  localparam int          INSTR_W      = 32;
  localparam int          PC_INC       = 4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous {pc, instr} buffer between fetch and decode
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [W-1:0]               head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  // flush dominates so a redirect never lets a stale word in or out
  assign do_push   = push && !flush;
  assign do_pop    = pop && !empty && !flush;
  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - PC owner, in-order imem fetch, redirect/drop handling
// Optional MISALIGN_TRAP_EN: misaligned redirect pulses misalign_trap and halts fetch.
module pc_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              XLEN       = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEF),
  parameter int              FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_target,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [XLEN-1:0]    if_pc,
  output logic [INSTR_W-1:0] if_instr,
  input  logic               if_ready,
  output logic               misalign_trap
);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  fetch_state_e          state;
  logic [XLEN-1:0]       pc;
  logic [XLEN-1:0]       resp_pc;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         drop_cnt;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [XLEN+INSTR_W-1:0] fifo_head;
  logic [CW:0]           in_use;
  logic                  grant;
  logic [XLEN-1:0]       target;
  logic                  misaligned;

`ifdef MISALIGN_TRAP_EN
  assign target     = redirect_target;
  assign misaligned = |redirect_target[1:0];
`else
  assign target     = redirect_target & ~XLEN'(3);
  assign misaligned = 1'b0;
`endif

  // credit: in-flight plus buffered words may never exceed the buffer size
  assign in_use    = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req  = (state == RUN) && !redirect_valid && (in_use < (CW+1)'(FIFO_DEPTH));
  assign imem_addr = pc;
  assign grant     = imem_req && imem_gnt;

  assign fifo_push = imem_rvalid && (drop_cnt == '0) && !redirect_valid;
  assign fifo_pop  = if_valid && if_ready && !redirect_valid;
  assign if_valid  = !fifo_empty;
  assign if_pc     = fifo_head[XLEN+INSTR_W-1:INSTR_W];
  assign if_instr  = fifo_head[INSTR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= BOOT;
      pc            <= RESET_PC;
      resp_pc       <= RESET_PC;
      outstanding   <= '0;
      drop_cnt      <= '0;
      misalign_trap <= 1'b0;
    end else begin
      misalign_trap <= 1'b0;
      if (redirect_valid) begin
        pc          <= target;
        resp_pc     <= target;
        // everything still in flight belongs to the old path
        drop_cnt    <= outstanding - CW'(imem_rvalid);
        outstanding <= outstanding - CW'(imem_rvalid);
        if (misaligned) begin
          misalign_trap <= 1'b1;
          state         <= HALT;
        end else begin
          state <= RUN;
        end
      end else begin
        if (state == BOOT) state <= RUN;
        if (grant) pc <= pc + XLEN'(PC_INC);
        outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid);
        if (imem_rvalid) begin
          if (drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
          else                resp_pc  <= resp_pc + XLEN'(PC_INC);
        end
      end
    end
  end

  fetch_fifo #(
    .W     (XLEN + INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data ({resp_pc, imem_rdata}),
    .pop       (fifo_pop),
    .flush     (redirect_valid),
    .head_data (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_push && fifo_full && !fifo_pop));
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - scoreboard bench for pc_fetch_ctrl with imem model
module tb_pc_fetch_ctrl;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        misalign_trap;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .if_ready        (if_ready),
    .misalign_trap   (misalign_trap)
  );

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;

  exp_t        exp_q[$];
  pend_t       pend_q[$];
  logic [31:0] redir_q[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_due = 0;
  int p_gnt, p_rdy, p_redir, lat_min, lat_max;
  int grant_cnt, pop_cnt;
  logic [31:0] pc_m;
  bit halted_m, boot_m, trap_exp, last_req;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF8;
    else t = $urandom & 32'h0000_0FFC;
    if ($urandom_range(0, 5) == 0) t[1:0] = 2'($urandom_range(1, 3));
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    pend_q.delete();
    redir_q.delete();
    pc_m      = 32'h0;
    halted_m  = 0;
    trap_exp  = 0;
    boot_m    = 1;
    grant_cnt = 0;
    pop_cnt   = 0;
    last_due  = 0;
  endtask

  task automatic quiet_inputs();
    redirect_valid  = 0;
    redirect_target = 0;
    imem_gnt        = 0;
    imem_rvalid     = 0;
    imem_rdata      = 0;
    if_ready        = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    quiet_inputs();
    #1;
    chk("reset_imem_req", imem_req, 0);
    chk("reset_if_valid", if_valid, 0);
    chk("reset_trap", misalign_trap, 0);
    clear_model();
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #3 rst_n = 0;
    #1;
    chk("async_rst_imem_req", imem_req, 0);
    chk("async_rst_if_valid", if_valid, 0);
    do_reset();
  endtask

  task automatic step();
    pend_t p;
    int lat, due;
    @(negedge clk);
    cyc++;
    if (redir_q.size() > 0) begin
      redirect_valid  = 1;
      redirect_target = redir_q.pop_front();
    end else if ($urandom_range(0, 99) < p_redir) begin
      redirect_valid  = 1;
      redirect_target = rand_target();
    end else begin
      redirect_valid  = 0;
      redirect_target = $urandom;
    end
    imem_gnt = ($urandom_range(0, 99) < p_gnt);
    if_ready = ($urandom_range(0, 99) < p_rdy);
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      p = pend_q.pop_front();
      imem_rvalid = 1;
      imem_rdata  = mem_word(p.addr);
    end else begin
      imem_rvalid = 0;
      imem_rdata  = $urandom;
    end
    #1;
    last_req = imem_req;
    chk("misalign_trap", misalign_trap, trap_exp);
    if (boot_m || halted_m || redirect_valid) chk("imem_req_low", imem_req, 0);
    boot_m = 0;
    if (imem_req && imem_gnt) begin
      grant_cnt++;
      lat = $urandom_range(lat_min, lat_max);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend_q.push_back('{addr: imem_addr, due: due});
      exp_q.push_back('{pc: pc_m, instr: mem_word(pc_m)});
      pc_m = pc_m + 32'd4;
    end
    trap_exp = 0;
    if (redirect_valid) begin
      exp_q.delete();
`ifdef MISALIGN_TRAP_EN
      trap_exp = (redirect_target[1:0] != 2'b00);
      halted_m = trap_exp;
      pc_m     = redirect_target;
`else
      pc_m     = redirect_target & ~32'h3;
`endif
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n && if_valid && if_ready && !redirect_valid) begin
      pop_cnt++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL pop_unexpected: got if_pc %h, expected no output", if_pc);
      end else begin
        e = exp_q.pop_front();
        chk("if_pc", if_pc, e.pc);
        chk("if_instr", if_instr, e.instr);
      end
    end
  end

  task automatic knobs(input int g, input int r, input int rd, input int lmin, input int lmax);
    p_gnt = g; p_rdy = r; p_redir = rd; lat_min = lmin; lat_max = lmax;
  endtask

  initial begin
    int held;
    quiet_inputs();
    knobs(100, 100, 0, 1, 1);
    do_reset();

    // in-order stream from reset
    repeat (12) step();
    chk("t1_pop_count_ge3", (pop_cnt >= 3), 1);

    // decode stalled: credit stops fetch after two words
    do_reset();
    knobs(100, 0, 0, 1, 1);
    repeat (10) step();
    chk("t2_grants", grant_cnt, 2);
    chk("t2_req_after_full", last_req, 0);
    chk("t2_if_valid", if_valid, 1);
    p_rdy = 100;
    repeat (10) step();
    chk("t2_resumed", (grant_cnt > 2), 1);

    // redirect with two requests outstanding
    do_reset();
    knobs(100, 100, 0, 4, 4);
    repeat (3) step();
    redir_q.push_back(32'h100);
    repeat (15) step();

    // redirect coinciding with response and pop
    knobs(100, 100, 0, 1, 1);
    repeat (6) step();
    redir_q.push_back(32'h180);
    repeat (8) step();

    // back-to-back redirects
    knobs(100, 100, 0, 3, 3);
    repeat (5) step();
    redir_q.push_back(32'h200);
    redir_q.push_back(32'h300);
    repeat (15) step();

    // misaligned redirect
    redir_q.push_back(32'h102);
    step();
    held = grant_cnt;
    repeat (6) step();
`ifdef MISALIGN_TRAP_EN
    chk("t6_halt_no_grants", grant_cnt, held);
    redir_q.push_back(32'h400);
    repeat (10) step();
`else
    chk("t6_fetch_continues", (grant_cnt > held), 1);
`endif

    // randomized traffic with a mid-burst reset
    knobs(70, 70, 5, 1, 4);
    repeat (1500) step();
    mid_reset();
    repeat (1500) step();

    // drain and confirm nothing kept was lost
    knobs(0, 100, 0, 1, 1);
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0 && pend_q.size() == 0) break;
      step();
    end
    repeat (3) step();
    chk("drain_expected_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
endmodule
